// File: rtl/wb_io_decoder.sv
// Wishbone classic master-to-N-slave decoder with windowed match, default responder and ack timeout.
// Registered decode: slave strobe one cycle after the master strobe, ack at the earliest two cycles later.
module wb_io_decoder #(
  parameter int NSLV = 8,
  parameter int AW = 19,
  parameter int DW = 16,
  parameter int TO_W = 8,
  parameter int TIMEOUT = 200,
  parameter logic [DW-1:0] DEF_DAT = '0
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic [AW:1]          m_adr_i,
  input  logic                 m_tga_i,
  input  logic                 m_we_i,
  input  logic                 m_stb_i,
  input  logic                 m_cyc_i,
  output logic [DW-1:0]        m_dat_o,
  output logic                 m_ack_o,
  output logic                 m_err_o,
  input  logic [NSLV*AW-1:0]   slv_base_i,
  input  logic [NSLV*AW-1:0]   slv_mask_i,
  input  logic [NSLV-1:0]      slv_tga_i,
  input  logic [NSLV-1:0]      slv_en_i,
  output logic [NSLV-1:0]      s_stb_o,
  input  logic [NSLV*DW-1:0]   s_dat_i,
  input  logic [NSLV-1:0]      s_ack_i,
  output logic [7:0]           to_cnt_o
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [NSLV-1:0] ONE = NSLV'(1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEL, DFLT, ACK} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [TO_W-1:0] cnt;
  logic            hit;
  logic [IW-1:0]   win;
  logic            sel_ack;
  logic [DW-1:0]   sel_dat;

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (slv_en_i[i] && (slv_tga_i[i] == m_tga_i) &&
          ((m_adr_i & slv_mask_i[i*AW +: AW]) ==
           (slv_base_i[i*AW +: AW] & slv_mask_i[i*AW +: AW]))) begin
        hit = 1'b1;
        win = IW'(i);
      end
    end
  end

  assign sel_ack = s_ack_i[idx];
  assign sel_dat = s_dat_i[idx*DW +: DW];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      s_stb_o  <= '0;
      m_ack_o  <= 1'b0;
      m_err_o  <= 1'b0;
      m_dat_o  <= '0;
      to_cnt_o <= '0;
    end else begin
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (m_stb_i && m_cyc_i) begin
            if (hit) begin
              idx     <= win;
              s_stb_o <= ONE << win;
              cnt     <= '0;
              state   <= SEL;
            end else begin
              state <= DFLT;
            end
          end
        end
        SEL: begin
          if (!m_cyc_i) begin
            s_stb_o <= '0;
            state   <= IDLE;
          end else if (sel_ack) begin
            s_stb_o <= '0;
            m_dat_o <= sel_dat;
            m_ack_o <= 1'b1;
            state   <= ACK;
          end else if (cnt == TO_LAST) begin
            s_stb_o <= '0;
            m_dat_o <= DEF_DAT;
            m_ack_o <= 1'b1;
            m_err_o <= 1'b1;
            if (to_cnt_o != 8'hFF) to_cnt_o <= to_cnt_o + 8'd1;
            state   <= ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DFLT: begin
          if (!m_cyc_i) begin
            state <= IDLE;
          end else begin
            m_dat_o <= DEF_DAT;
            m_ack_o <= 1'b1;
            state   <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writes follow exactly the same routing; the direction is the slaves' concern.
  logic unused_we;
  assign unused_we = m_we_i;

endmodule

// File: tb/tb_wb_io_decoder.sv
// Directed bench for wb_io_decoder: routing, priority, default responder, timeout, abort, reset.
module tb_wb_io_decoder;
  localparam int NSLV = 8;
  localparam int AW = 19;
  localparam int DW = 16;
  localparam logic [15:0] DEF = 16'hDEAD;

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_n_i = 1'b0;
  logic [AW:1]         m_adr_i = '0;
  logic                m_tga_i = 1'b0;
  logic                m_we_i = 1'b0;
  logic                m_stb_i = 1'b0;
  logic                m_cyc_i = 1'b0;
  logic [DW-1:0]       m_dat_o;
  logic                m_ack_o;
  logic                m_err_o;
  logic [NSLV*AW-1:0]  slv_base_i = '0;
  logic [NSLV*AW-1:0]  slv_mask_i = '0;
  logic [NSLV-1:0]     slv_tga_i = '0;
  logic [NSLV-1:0]     slv_en_i = '0;
  logic [NSLV-1:0]     s_stb_o;
  logic [NSLV*DW-1:0]  s_dat_i = '0;
  logic [NSLV-1:0]     s_ack_i = '0;
  logic [7:0]          to_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  wb_io_decoder #(.NSLV(NSLV), .AW(AW), .DW(DW), .TO_W(8), .TIMEOUT(10), .DEF_DAT(DEF)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .m_adr_i(m_adr_i), .m_tga_i(m_tga_i), .m_we_i(m_we_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .slv_base_i(slv_base_i), .slv_mask_i(slv_mask_i), .slv_tga_i(slv_tga_i), .slv_en_i(slv_en_i),
    .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .to_cnt_o(to_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic start(input logic [AW:1] adr, input logic tga, input logic we);
    m_adr_i = adr; m_tga_i = tga; m_we_i = we; m_stb_i = 1'b1; m_cyc_i = 1'b1;
  endtask

  task automatic finish_cyc();
    m_stb_i = 1'b0; m_cyc_i = 1'b0; s_ack_i = '0;
  endtask

  task automatic cfg(input int i, input logic [AW:1] base, input logic [AW:1] mask,
                     input logic tga, input logic en, input logic [15:0] dat);
    slv_base_i[i*AW +: AW] = base;
    slv_mask_i[i*AW +: AW] = mask;
    slv_tga_i[i] = tga;
    slv_en_i[i] = en;
    s_dat_i[i*DW +: DW] = dat;
  endtask

  // Unmapped access: nothing strobed, ack with DEF in the third cycle, no error.
  task automatic dflt_access(input string tag, input logic [AW:1] adr, input logic tga);
    start(adr, tga, 1'b0);
    tick();
    check({tag, "_c2_ack"}, {31'd0, m_ack_o}, 32'd0);
    check({tag, "_c2_stb"}, {24'd0, s_stb_o}, 32'd0);
    tick();
    check({tag, "_c3_ack"}, {31'd0, m_ack_o}, 32'd1);
    check({tag, "_c3_dat"}, {16'd0, m_dat_o}, {16'd0, DEF});
    check({tag, "_c3_err"}, {31'd0, m_err_o}, 32'd0);
    finish_cyc();
    tick();
    check({tag, "_c4_ack"}, {31'd0, m_ack_o}, 32'd0);
  endtask

  task automatic timeout_access(output int stb_cycles, output logic ack, output logic err);
    start(19'h20000, 1'b0, 1'b0);
    tick();
    stb_cycles = 0;
    while (s_stb_o[3] && stb_cycles < 50) begin
      stb_cycles++;
      tick();
    end
    ack = m_ack_o;
    err = m_err_o;
  endtask

  initial begin
    int n;
    int errs;
    logic a, e;

    cfg(0, 19'h0F100, 19'h7FF00, 1'b1, 1'b0, 16'h0A0A);
    cfg(1, 19'h60000, 19'h70000, 1'b0, 1'b1, 16'h1111);
    cfg(2, 19'h0F100, 19'h7FF00, 1'b1, 1'b1, 16'hBEEF);
    cfg(3, 19'h20000, 19'h70000, 1'b0, 1'b1, 16'h3333);
    cfg(5, 19'h40000, 19'h40000, 1'b0, 1'b1, 16'h5555);

    #1;
    check("rst_ack", {31'd0, m_ack_o}, 32'd0);
    check("rst_stb", {24'd0, s_stb_o}, 32'd0);
    check("rst_dat", {16'd0, m_dat_o}, 32'd0);
    check("rst_to", {24'd0, to_cnt_o}, 32'd0);
    tick();
    wb_rst_n_i = 1'b1;
    tick();

    // Read from slave 2; slave 5 acking meanwhile must be ignored.
    start(19'h0F164, 1'b1, 1'b0);
    tick();
    check("rd_stb", {24'd0, s_stb_o}, 32'h04);
    s_ack_i[5] = 1'b1;
    tick();
    check("rd_foreign_ack", {31'd0, m_ack_o}, 32'd0);
    check("rd_stb_hold", {24'd0, s_stb_o}, 32'h04);
    s_ack_i[5] = 1'b0;
    s_ack_i[2] = 1'b1;
    tick();
    check("rd_ack", {31'd0, m_ack_o}, 32'd1);
    check("rd_dat", {16'd0, m_dat_o}, 32'hBEEF);
    check("rd_err", {31'd0, m_err_o}, 32'd0);
    check("rd_stb_drop", {24'd0, s_stb_o}, 32'd0);
    finish_cyc();
    tick();
    check("rd_ack_pulse", {31'd0, m_ack_o}, 32'd0);

    // Overlap of slaves 1 and 5 (write); address change mid-access is ignored.
    start(19'h60000, 1'b0, 1'b1);
    tick();
    check("ovl_stb", {24'd0, s_stb_o}, 32'h02);
    m_adr_i = 19'h0F100; m_tga_i = 1'b1;
    tick();
    check("ovl_stb_latched", {24'd0, s_stb_o}, 32'h02);
    s_ack_i[1] = 1'b1;
    tick();
    check("ovl_ack", {31'd0, m_ack_o}, 32'd1);
    check("ovl_dat", {16'd0, m_dat_o}, 32'h1111);
    finish_cyc();
    tick();

    dflt_access("unm_io", 19'h00064, 1'b1);
    dflt_access("tga_mis", 19'h0F100, 1'b0);

    // First timeout.
    timeout_access(n, a, e);
    check("to_stb_cycles", n, 10);
    check("to_ack", {31'd0, a}, 32'd1);
    check("to_err", {31'd0, e}, 32'd1);
    check("to_dat", {16'd0, m_dat_o}, {16'd0, DEF});
    check("to_cnt1", {24'd0, to_cnt_o}, 32'd1);
    finish_cyc();
    tick();
    check("to_err_pulse", {31'd0, m_err_o}, 32'd0);

    // Ack arriving on the final timeout cycle wins.
    start(19'h20000, 1'b0, 1'b0);
    tick();
    repeat (9) tick();
    check("ato_stb", {24'd0, s_stb_o}, 32'h08);
    s_ack_i[3] = 1'b1;
    tick();
    check("ato_ack", {31'd0, m_ack_o}, 32'd1);
    check("ato_err", {31'd0, m_err_o}, 32'd0);
    check("ato_dat", {16'd0, m_dat_o}, 32'h3333);
    check("ato_cnt", {24'd0, to_cnt_o}, 32'd1);
    finish_cyc();
    tick();

    // 299 more timeouts: the counter saturates.
    errs = 0;
    for (int k = 0; k < 299; k++) begin
      timeout_access(n, a, e);
      if (a && e) errs++;
      finish_cyc();
      tick();
    end
    check("sat_err_seen", errs, 299);
    check("sat_cnt", {24'd0, to_cnt_o}, 32'd255);

    // Master abort in SEL.
    start(19'h0F100, 1'b1, 1'b0);
    tick();
    check("abt_stb", {24'd0, s_stb_o}, 32'h04);
    finish_cyc();
    tick();
    check("abt_stb_drop", {24'd0, s_stb_o}, 32'd0);
    check("abt_ack", {31'd0, m_ack_o}, 32'd0);
    tick();
    check("abt_ack2", {31'd0, m_ack_o}, 32'd0);
    dflt_access("post_abt", 19'h00064, 1'b1);

    // Asynchronous reset in SEL, well before the next edge.
    start(19'h0F100, 1'b1, 1'b0);
    tick();
    check("ar_stb_pre", {24'd0, s_stb_o}, 32'h04);
    #3 wb_rst_n_i = 1'b0;
    #1;
    check("ar_stb", {24'd0, s_stb_o}, 32'd0);
    check("ar_dat", {16'd0, m_dat_o}, 32'd0);
    check("ar_to", {24'd0, to_cnt_o}, 32'd0);
    check("ar_ack", {31'd0, m_ack_o}, 32'd0);
    finish_cyc();
    tick();
    wb_rst_n_i = 1'b1;
    tick();
    dflt_access("post_rst", 19'h00064, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
